// File: rtl/e203_fmis_pkg.sv
// Shared constants for the FPU misc-op dispatcher: unit indices and default widths.
package e203_fmis_pkg;

  localparam int unsigned FMIS_U_SGNJ    = 0;
  localparam int unsigned FMIS_U_MV      = 1;
  localparam int unsigned FMIS_U_CVTWS   = 2;
  localparam int unsigned FMIS_U_CVTSW   = 3;
  localparam int unsigned FMIS_U_SQRT    = 4;
  localparam int unsigned FMIS_U_CLASS   = 5;
  localparam int unsigned FMIS_NUM_UNITS = 6;

  localparam int unsigned FMIS_XLEN   = 32;
  localparam int unsigned FMIS_ITAG_W = 2;
  localparam int unsigned FMIS_DEPTH  = 4;
  localparam int unsigned FMIS_UIDX_W = $clog2(FMIS_NUM_UNITS);

endpackage

// File: rtl/e203_exu_fpu_fmis_disp_if.sv
// Issue and write-back handshake bundle between the FMIS issuer and the dispatcher.
interface e203_exu_fpu_fmis_disp_if
  import e203_fmis_pkg::*;
#(
  parameter int unsigned NUM_UNITS = FMIS_NUM_UNITS,
  parameter int unsigned XLEN      = FMIS_XLEN,
  parameter int unsigned ITAG_W    = FMIS_ITAG_W
);
  logic                 i_valid;
  logic                 i_ready;
  logic [NUM_UNITS-1:0] i_unit_sel;
  logic [ITAG_W-1:0]    i_itag;
  logic                 flush_pulse;
  logic                 o_valid;
  logic                 o_ready;
  logic [XLEN-1:0]      o_wdat;
  logic                 o_err;
  logic [ITAG_W-1:0]    o_itag;

  modport master (
    output i_valid, i_unit_sel, i_itag, flush_pulse, o_ready,
    input  i_ready, o_valid, o_wdat, o_err, o_itag
  );

  modport slave (
    input  i_valid, i_unit_sel, i_itag, flush_pulse, o_ready,
    output i_ready, o_valid, o_wdat, o_err, o_itag
  );
endinterface

// File: rtl/e203_exu_fpu_fmis_ordq.sv
// Issue-order queue: circular FIFO of {uidx, itag, illegal, kill} with flush-kill-all.
module e203_exu_fpu_fmis_ordq #(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned UIDX_W = 3,
  parameter  int unsigned ITAG_W = 2,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned PW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [UIDX_W-1:0] push_uidx,
  input  logic [ITAG_W-1:0] push_itag,
  input  logic              push_illegal,
  input  logic              pop,
  input  logic              flush,
  output logic [UIDX_W-1:0] head_uidx,
  output logic [ITAG_W-1:0] head_itag,
  output logic              head_illegal,
  output logic              head_kill,
  output logic [PW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [DEPTH-1:0]  ent_vld, ent_kill, ent_ill;
  logic [DEPTH-1:0]  vld_n, kill_n, ill_n;
  logic [UIDX_W-1:0] ent_uidx [DEPTH];
  logic [ITAG_W-1:0] ent_itag [DEPTH];
  logic              push_ok, pop_ok;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign count   = wr_ptr - rd_ptr;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_uidx    = ent_uidx[rd_idx];
  assign head_itag    = ent_itag[rd_idx];
  assign head_illegal = ent_ill[rd_idx];
  assign head_kill    = ent_kill[rd_idx];

  // Flush marks everything live as killed; pop and push then update their own slots.
  always_comb begin
    vld_n  = ent_vld;
    kill_n = ent_kill;
    ill_n  = ent_ill;
    if (flush) kill_n = ent_kill | ent_vld;
    if (pop_ok) begin
      vld_n[rd_idx]  = 1'b0;
      kill_n[rd_idx] = 1'b0;
    end
    if (push_ok) begin
      vld_n[wr_idx]  = 1'b1;
      kill_n[wr_idx] = 1'b0;
      ill_n[wr_idx]  = push_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ent_vld  <= '0;
      ent_kill <= '0;
      ent_ill  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_uidx[i] <= '0;
        ent_itag[i] <= '0;
      end
    end else begin
      ent_vld  <= vld_n;
      ent_kill <= kill_n;
      ent_ill  <= ill_n;
      if (push_ok) begin
        ent_uidx[wr_idx] <= push_uidx;
        ent_itag[wr_idx] <= push_itag;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/e203_exu_fpu_fmis_disp.sv
// FMIS dispatcher: issues to one-hot selected sub-units, returns results in issue order.
module e203_exu_fpu_fmis_disp
  import e203_fmis_pkg::*;
#(
  parameter  int unsigned NUM_UNITS = FMIS_NUM_UNITS,
  parameter  int unsigned XLEN      = FMIS_XLEN,
  parameter  int unsigned ITAG_W    = FMIS_ITAG_W,
  parameter  int unsigned DEPTH     = FMIS_DEPTH,
  localparam int unsigned UIDX_W    = $clog2(NUM_UNITS),
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  e203_exu_fpu_fmis_disp_if.slave   bus,
  output logic [NUM_UNITS-1:0]      u_i_valid,
  input  logic [NUM_UNITS-1:0]      u_i_ready,
  input  logic [NUM_UNITS-1:0]      u_o_valid,
  output logic [NUM_UNITS-1:0]      u_o_ready,
  input  logic [NUM_UNITS*XLEN-1:0] u_o_wdat,
  input  logic [NUM_UNITS-1:0]      u_o_err,
  output logic                      busy,
  output logic [CNT_W-1:0]          outstanding
);

  logic              illegal, sel_unit_ready, can_issue, push, pop;
  logic [UIDX_W-1:0] sel_uidx, head_uidx;
  logic [ITAG_W-1:0] head_itag;
  logic              head_illegal, head_kill, kill_eff, q_full, q_empty;

  assign illegal        = (bus.i_unit_sel == '0);
  assign sel_unit_ready = |(bus.i_unit_sel & u_i_ready);
  assign can_issue      = !q_full && !bus.flush_pulse;
  assign bus.i_ready    = can_issue && (sel_unit_ready || illegal);
  assign u_i_valid      = {NUM_UNITS{bus.i_valid && can_issue}} & bus.i_unit_sel;
  assign push           = bus.i_valid && bus.i_ready;
  assign busy           = !q_empty;
  assign kill_eff       = head_kill || bus.flush_pulse;

  // One-hot to index; illegal ops encode as 0 and never route to a unit.
  always_comb begin
    sel_uidx = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      if (bus.i_unit_sel[k]) sel_uidx = sel_uidx | UIDX_W'(k);
  end

  e203_exu_fpu_fmis_ordq #(
    .DEPTH  (DEPTH),
    .UIDX_W (UIDX_W),
    .ITAG_W (ITAG_W)
  ) u_ordq (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_uidx    (sel_uidx),
    .push_itag    (bus.i_itag),
    .push_illegal (illegal),
    .pop          (pop),
    .flush        (bus.flush_pulse),
    .head_uidx    (head_uidx),
    .head_itag    (head_itag),
    .head_illegal (head_illegal),
    .head_kill    (head_kill),
    .count        (outstanding),
    .full         (q_full),
    .empty        (q_empty)
  );

  // Head routing: live heads forward to write-back, killed heads drain silently.
  always_comb begin
    bus.o_valid = 1'b0;
    bus.o_wdat  = '0;
    bus.o_err   = 1'b0;
    bus.o_itag  = head_itag;
    u_o_ready   = '0;
    pop         = 1'b0;
    if (!q_empty) begin
      if (head_illegal) begin
        if (kill_eff) begin
          pop = 1'b1;
        end else begin
          bus.o_valid = 1'b1;
          bus.o_err   = 1'b1;
          pop         = bus.o_ready;
        end
      end else begin
        for (int k = 0; k < NUM_UNITS; k++) begin
          if (head_uidx == UIDX_W'(k)) begin
            if (kill_eff) begin
              u_o_ready[k] = 1'b1;
              pop          = u_o_valid[k];
            end else begin
              bus.o_valid  = u_o_valid[k];
              bus.o_wdat   = u_o_wdat[k*XLEN +: XLEN];
              bus.o_err    = u_o_err[k];
              u_o_ready[k] = bus.o_ready;
              pop          = u_o_valid[k] && bus.o_ready;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_disp.sv
// Bench for the FMIS dispatcher: behavioural sub-units plus an in-order write-back scoreboard.
module tb_e203_exu_fpu_fmis_disp;
  import e203_fmis_pkg::*;

  localparam int N = 6;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e203_exu_fpu_fmis_disp_if #(.NUM_UNITS(N), .XLEN(XL), .ITAG_W(2)) bus ();

  logic [N-1:0]    u_i_valid, u_i_ready, u_o_valid, u_o_ready, u_o_err;
  logic [N*XL-1:0] u_o_wdat;
  logic            busy;
  logic [2:0]      outstanding;

  e203_exu_fpu_fmis_disp #(.NUM_UNITS(N), .XLEN(XL), .ITAG_W(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .u_i_valid(u_i_valid), .u_i_ready(u_i_ready), .u_o_valid(u_o_valid),
    .u_o_ready(u_o_ready), .u_o_wdat(u_o_wdat), .u_o_err(u_o_err),
    .busy(busy), .outstanding(outstanding)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wb_cnt  = 0;

  // Sub-unit models: one op at a time, result after lat cycles, held until drained.
  logic [N-1:0] mbusy = '0;
  logic [N-1:0] hold  = '0;
  int           mcnt    [N];
  int           lat     [N];
  logic [XL-1:0] mdat   [N];
  logic [XL-1:0] nxt_dat[N];
  logic          merr   [N];
  logic          nxt_err[N];

  always_comb begin
    u_o_wdat = '0;
    for (int k = 0; k < N; k++) begin
      u_i_ready[k] = !mbusy[k];
      u_o_valid[k] = mbusy[k] && (mcnt[k] == 0) && !hold[k];
      u_o_err[k]   = merr[k];
      u_o_wdat[k*XL +: XL] = mdat[k];
    end
  end

  initial begin
    logic [N-1:0] acc, drn;
    logic r;
    for (int k = 0; k < N; k++) begin
      mcnt[k] = 0; mdat[k] = '0; merr[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      acc = u_i_valid & u_i_ready;
      drn = u_o_valid & u_o_ready;
      r   = rst;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (r) mbusy[k] = 1'b0;
        else begin
          if (drn[k]) mbusy[k] = 1'b0;
          if (acc[k]) begin
            mbusy[k] = 1'b1; mcnt[k] = lat[k]; mdat[k] = nxt_dat[k]; merr[k] = nxt_err[k];
          end else if (mbusy[k] && mcnt[k] > 0) mcnt[k] = mcnt[k] - 1;
        end
      end
    end
  end

  // Scoreboard: expectation pushed at issue accept, popped at write-back.
  typedef struct { logic [1:0] itag; logic [XL-1:0] dat; logic err; } exp_t;
  exp_t       sb[$];
  logic [1:0] wb_log[$];

  initial begin
    exp_t e;
    int   u;
    forever begin
      @(negedge clk);
      if (rst) sb.delete();
      else begin
        if (bus.o_valid && bus.o_ready) begin
          n_tests++; wb_cnt++;
          wb_log.push_back(bus.o_itag);
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got itag=%0d wdat=%h, required no write-back", bus.o_itag, bus.o_wdat);
          end else begin
            e = sb.pop_front();
            if (bus.o_itag !== e.itag || bus.o_wdat !== e.dat || bus.o_err !== e.err) begin
              n_fail++;
              $display("FAIL wb_data: got itag=%0d wdat=%h err=%b, required itag=%0d wdat=%h err=%b",
                       bus.o_itag, bus.o_wdat, bus.o_err, e.itag, e.dat, e.err);
            end
          end
        end
        if (bus.flush_pulse) sb.delete();
        if (bus.i_valid && bus.i_ready) begin
          u = -1;
          for (int k = 0; k < N; k++) if (bus.i_unit_sel[k]) u = k;
          e.itag = bus.i_itag;
          e.dat  = (u < 0) ? '0 : nxt_dat[u];
          e.err  = (u < 0) ? 1'b1 : nxt_err[u];
          sb.push_back(e);
        end
      end
    end
  end

  always @(negedge clk)
    if (!rst && bus.i_valid)
      assert ($countones(bus.i_unit_sel) <= 1) else $error("non-one-hot i_unit_sel %b", bus.i_unit_sel);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [N-1:0] sel, input logic [1:0] itag, output logic [N-1:0] uiv);
    int c = 0;
    bus.i_valid = 1'b1; bus.i_unit_sel = sel; bus.i_itag = itag;
    do begin @(negedge clk); c++; end while (!bus.i_ready && c < 50);
    uiv = u_i_valid;
    if (!bus.i_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: i_ready=0 after %0d cycles, required 1", c);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_unit_sel = '0;
  endtask

  task automatic wait_drain();
    int c = 0;
    do begin @(negedge clk); c++; end while ((sb.size() != 0 || outstanding != 0) && c < 100);
    n_tests++;
    if (sb.size() != 0 || outstanding != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: sb=%0d outstanding=%0d, required 0/0", sb.size(), outstanding);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d, required 0", outstanding); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_valid: got %b, required 0", bus.o_valid); end
    n_tests++; if (u_o_ready !== 6'd0) begin n_fail++; $display("FAIL rst_u_o_ready: got %b, required 0", u_o_ready); end
    n_tests++; if (u_i_valid !== 6'd0) begin n_fail++; $display("FAIL rst_u_i_valid: got %b, required 0", u_i_valid); end
    n_tests++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL rst_i_ready: got %b, required 1", bus.i_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [N-1:0] uiv;
    int c = 0;
    lat[FMIS_U_SGNJ] = 3; nxt_dat[FMIS_U_SGNJ] = 32'h3F80_0000; nxt_err[FMIS_U_SGNJ] = 1'b0;
    issue(6'b000001, 2'd2, uiv);
    n_tests++; if (uiv !== 6'b000001) begin n_fail++; $display("FAIL single_u_i_valid: got %b, required 000001", uiv); end
    do begin
      @(negedge clk); c++;
      if (c == 1) begin
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_outstanding1: got %0d, required 1", outstanding); end
      end
    end while (!bus.o_valid && c < 20);
    n_tests++; if (c != 4) begin n_fail++; $display("FAIL single_latency: o_valid after %0d cycles, required 4", c); end
    n_tests++; if (bus.o_itag !== 2'd2 || bus.o_wdat !== 32'h3F80_0000) begin
      n_fail++; $display("FAIL single_result: got itag=%0d wdat=%h, required 2/3f800000", bus.o_itag, bus.o_wdat);
    end
    @(negedge clk);
    n_tests++; if (outstanding !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_outstanding0: got %0d busy=%b, required 0/0", outstanding, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_order();
    logic [N-1:0] uiv;
    lat[FMIS_U_SQRT] = 10; nxt_dat[FMIS_U_SQRT] = 32'h4000_0000; nxt_err[FMIS_U_SQRT] = 1'b0;
    lat[FMIS_U_MV]   = 0;  nxt_dat[FMIS_U_MV]   = 32'h1234_5678; nxt_err[FMIS_U_MV]   = 1'b0;
    wb_log.delete();
    issue(6'b1 << FMIS_U_SQRT, 2'd0, uiv);
    issue(6'b1 << FMIS_U_MV, 2'd1, uiv);
    @(negedge clk);
    n_tests++; if (u_o_valid[FMIS_U_MV] !== 1'b1 || u_o_ready[FMIS_U_MV] !== 1'b0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL order_hold: got mv_valid=%b mv_ready=%b o_valid=%b, required 1/0/0",
                         u_o_valid[FMIS_U_MV], u_o_ready[FMIS_U_MV], bus.o_valid);
    end
    @(posedge clk); #1;
    wait_drain();
    n_tests++; if (wb_log.size() != 2 || wb_log[0] !== 2'd0 || wb_log[1] !== 2'd1) begin
      n_fail++; $display("FAIL order_seq: got %0d write-backs, required 2 (itag0 then itag1)", wb_log.size());
    end
  endtask

  task automatic test_full();
    logic [N-1:0] uiv;
    for (int k = 0; k < N; k++) begin
      lat[k] = 0; nxt_dat[k] = 32'hA000_0000 + 32'(k); nxt_err[k] = (k == FMIS_U_CVTWS);
    end
    hold = '1;
    for (int k = 0; k < 4; k++) issue(6'b1 << k, 2'(k), uiv);
    bus.i_valid = 1'b1; bus.i_unit_sel = 6'b1 << FMIS_U_SQRT; bus.i_itag = 2'd0;
    repeat (3) begin
      @(negedge clk);
      n_tests++; if (bus.i_ready !== 1'b0 || outstanding !== 3'd4 || u_i_valid !== 6'd0) begin
        n_fail++; $display("FAIL full_block: got i_ready=%b outstanding=%0d u_i_valid=%b, required 0/4/0",
                           bus.i_ready, outstanding, u_i_valid);
      end
    end
    @(posedge clk); #1 hold[0] = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b1 || bus.i_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_cycle: got o_valid=%b i_ready=%b, required 1/0", bus.o_valid, bus.i_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.i_ready !== 1'b1 || outstanding !== 3'd3) begin
      n_fail++; $display("FAIL full_reopen: got i_ready=%b outstanding=%0d, required 1/3", bus.i_ready, outstanding);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_unit_sel = '0; hold = '0;
    wait_drain();
  endtask

  task automatic test_illegal();
    logic [N-1:0] uiv;
    issue(6'b000000, 2'd3, uiv);
    n_tests++; if (uiv !== 6'd0) begin n_fail++; $display("FAIL illegal_u_i_valid: got %b, required 0", uiv); end
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b1 || bus.o_err !== 1'b1 || bus.o_wdat !== 32'd0 || bus.o_itag !== 2'd3) begin
      n_fail++; $display("FAIL illegal_wb: got v=%b err=%b wdat=%h itag=%0d, required 1/1/0/3",
                         bus.o_valid, bus.o_err, bus.o_wdat, bus.o_itag);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_flush();
    logic [N-1:0] uiv;
    int wb0;
    hold = '1;
    issue(6'b1 << FMIS_U_SGNJ, 2'd0, uiv);
    issue(6'b1 << FMIS_U_MV, 2'd2, uiv);
    issue(6'b1 << FMIS_U_CVTWS, 2'd3, uiv);
    wb0 = wb_cnt;
    bus.flush_pulse = 1'b1;
    bus.i_valid = 1'b1; bus.i_unit_sel = 6'b1 << FMIS_U_CVTSW; bus.i_itag = 2'd1;
    @(negedge clk);
    n_tests++; if (bus.i_ready !== 1'b0 || u_i_valid !== 6'd0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: got i_ready=%b u_i_valid=%b o_valid=%b, required 0/0/0",
                         bus.i_ready, u_i_valid, bus.o_valid);
    end
    @(posedge clk); #1;
    bus.flush_pulse = 1'b0; bus.i_valid = 1'b0; hold = '0;
    nxt_dat[FMIS_U_CVTSW] = 32'hBEEF_0001; nxt_err[FMIS_U_CVTSW] = 1'b0;
    issue(6'b1 << FMIS_U_CVTSW, 2'd1, uiv);
    wait_drain();
    n_tests++; if (wb_cnt - wb0 != 1 || wb_log[wb_log.size()-1] !== 2'd1) begin
      n_fail++; $display("FAIL flush_wb_count: got %0d write-backs, required 1 (itag1)", wb_cnt - wb0);
    end
    n_tests++; if (mbusy !== 6'd0) begin n_fail++; $display("FAIL flush_drained: got unit busy=%b, required 0", mbusy); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] uiv;
    logic [XL-1:0] w0;
    logic [1:0] t0;
    hold = '1;
    issue(6'b1 << FMIS_U_SQRT, 2'd2, uiv);
    issue(6'b1 << FMIS_U_CLASS, 2'd3, uiv);
    bus.o_ready = 1'b0; hold = '0;
    @(negedge clk);
    w0 = bus.o_wdat; t0 = bus.o_itag;
    n_tests++; if (bus.o_valid !== 1'b1 || w0 !== nxt_dat[FMIS_U_SQRT] || t0 !== 2'd2) begin
      n_fail++; $display("FAIL stall_first: got v=%b wdat=%h itag=%0d, required 1/%h/2", bus.o_valid, w0, t0, nxt_dat[FMIS_U_SQRT]);
    end
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b1 || bus.o_wdat !== w0 || bus.o_itag !== t0 || outstanding !== 3'd2) begin
      n_fail++; $display("FAIL stall_hold: got v=%b wdat=%h itag=%0d outstanding=%0d, required 1/%h/%0d/2",
                         bus.o_valid, bus.o_wdat, bus.o_itag, outstanding, w0, t0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if (outstanding !== 3'd0 || busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst: got outstanding=%0d busy=%b o_valid=%b, required 0/0/0", outstanding, busy, bus.o_valid);
    end
    @(posedge clk); #1 bus.o_ready = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin lat[k] = 0; nxt_dat[k] = '0; nxt_err[k] = 1'b0; end
    bus.i_valid = 1'b0; bus.i_unit_sel = '0; bus.i_itag = '0;
    bus.flush_pulse = 1'b0; bus.o_ready = 1'b1;
    do_reset();
    test_reset();
    test_single();
    test_order();
    test_full();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
